// File: rtl/ddr_axi_rd_engine.sv
// AXI4 read engine: accepts one AR burst at a time, issues single-beat native reads, and returns them on R.
// Optional RD_ENGINE_PERF_CNT_EN adds saturating rd_beat_cnt / rd_stall_cnt output counters.
module ddr_axi_rd_engine #(
    parameter int DATA_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 8,
    parameter int RUSER_WIDTH = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [ID_WIDTH-1:0]    arid,
    input  logic [ADDR_WIDTH-1:0]  araddr,
    input  logic [7:0]             arlen,
    input  logic [1:0]             arburst,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [ID_WIDTH-1:0]    rid,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic [RUSER_WIDTH-1:0] ruser,
    output logic                   rvalid,
    input  logic                   rready,
    input  logic                   rd_busy,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic                   rd_addr_en,
    output logic                   rd_en,
    input  logic                   rd_ack,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_valid
`ifdef RD_ENGINE_PERF_CNT_EN
    ,
    output logic [31:0]            rd_beat_cnt,
    output logic [31:0]            rd_stall_cnt
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ID_WIDTH-1:0]   ar_id;
    logic [7:0]            ar_len;
    logic                  ar_fixed;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [8:0]            issue_cnt;
    logic [7:0]            rbeat_cnt;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic                  held;
    logic                  ar_rdy;

    logic ar_hs, ack, push, pop, last_hs, credit_zero, issue_left, fire;

    assign ar_hs       = arvalid & arready;
    assign ack         = rd_addr_en & rd_ack;
    // Returns with nothing outstanding belong to an aborted burst and are dropped.
    assign push        = rd_valid & (outstanding != '0);
    assign pop         = rvalid & rready;
    assign last_hs     = pop & rlast;
    assign credit_zero = (outstanding + fifo_cnt) == CNT_W'(FIFO_DEPTH);
    assign issue_left  = issue_cnt <= {1'b0, ar_len};
    assign fire        = (state == ISSUE) & ~held & issue_left & ~credit_zero & ~rd_busy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = ISSUE;
            ISSUE:   if (ack && (issue_cnt == {1'b0, ar_len})) state_nxt = DRAIN;
            DRAIN:   if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        arready    = ar_rdy;
        rd_addr_en = held | fire;
        rd_en      = held | fire;
        rd_addr    = cur_addr;
        rid        = ar_id;
        rvalid     = (fifo_cnt != '0);
        rdata      = rvalid ? mem[rd_ptr] : '0;
        rlast      = rvalid & (rbeat_cnt == ar_len);
        rresp      = 2'b00;
        ruser      = '0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_rdy      <= 1'b0;
            ar_id       <= '0;
            ar_len      <= '0;
            ar_fixed    <= 1'b0;
            cur_addr    <= '0;
            issue_cnt   <= '0;
            rbeat_cnt   <= '0;
            held        <= 1'b0;
            outstanding <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            ar_rdy      <= (state_nxt == IDLE);
            outstanding <= outstanding + CNT_W'(ack) - CNT_W'(push);
            fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            if (ack)       held <= 1'b0;
            else if (fire) held <= 1'b1;
            if (ack) begin
                issue_cnt <= issue_cnt + 9'd1;
                if (!ar_fixed) cur_addr <= cur_addr + BEAT_BYTES;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                rbeat_cnt <= rbeat_cnt + 8'd1;
            end
            if (ar_hs) begin
                ar_id     <= arid;
                ar_len    <= arlen;
                ar_fixed  <= (arburst == 2'b00);
                cur_addr  <= araddr;
                issue_cnt <= '0;
                rbeat_cnt <= '0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= rd_data;
    end

`ifdef RD_ENGINE_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic stall;
    assign stall = ((state == ISSUE) & ~held & issue_left & (rd_busy | credit_zero)) | (held & rd_busy);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_beat_cnt  <= '0;
            rd_stall_cnt <= '0;
        end else begin
            if (pop)   rd_beat_cnt  <= sat_inc(rd_beat_cnt);
            if (stall) rd_stall_cnt <= sat_inc(rd_stall_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_ddr_axi_rd_engine.sv
// Randomized bench for ddr_axi_rd_engine: behavioural controller, burst address model and R-channel scoreboard.
module tb_ddr_axi_rd_engine;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 8;
    localparam int UW = 1;
    localparam int FD = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [1:0]    arburst = 2'b01;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic [UW-1:0] ruser;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          rd_busy = 1'b0;
    logic [AW-1:0] rd_addr;
    logic          rd_addr_en;
    logic          rd_en;
    logic          rd_ack = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          rd_valid = 1'b0;
`ifdef RD_ENGINE_PERF_CNT_EN
    logic [31:0]   rd_beat_cnt;
    logic [31:0]   rd_stall_cnt;
`endif

    ddr_axi_rd_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .RUSER_WIDTH(UW), .FIFO_DEPTH(FD)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
        .rvalid(rvalid), .rready(rready),
        .rd_busy(rd_busy), .rd_addr(rd_addr), .rd_addr_en(rd_addr_en), .rd_en(rd_en),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid)
`ifdef RD_ENGINE_PERF_CNT_EN
        , .rd_beat_cnt(rd_beat_cnt), .rd_stall_cnt(rd_stall_cnt)
`endif
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Current burst as seen by the reference model
    logic [IW-1:0] b_id = '0;
    logic [31:0]   b_addr = '0;
    logic [7:0]    b_len = '0;
    bit            b_fixed = 1'b0;
    logic [31:0]   b_salt = '0;
    int            ack_cnt = 0;
    int            beat_cnt = 0;
    int            total_beats = 0;
    bit            burst_done = 1'b0;

    function automatic logic [31:0] exp_addr(input int i);
        return b_fixed ? b_addr : b_addr + 32'(i) * 32'(DW / 8);
    endfunction

    function automatic logic [127:0] beat_data(input int i, input logic [31:0] a);
        return {32'(i), a, b_salt, 32'h0000_00A5};
    endfunction

    // Controller / R-sink knobs
    int  ncyc = 0;
    int  ack_wait = 0;
    int  ack_lat = 0;
    int  ack_lat_min = 0;
    int  ack_lat_max = 0;
    int  ret_lat_min = 3;
    int  ret_lat_max = 3;
    int  last_due = 0;
    int  rready_mode = 1;
    bit  busy_force = 1'b0;
    bit  busy_rand = 1'b0;
    logic [127:0] ret_q[$];
    int           due_q[$];
    bit           pend = 1'b0;
    logic [31:0]  pend_addr = '0;
    bit           hold_chk = 1'b0;
    logic [IW-1:0] hold_id = '0;
    logic [127:0]  hold_data = '0;
    logic          hold_last = 1'b0;

    always @(negedge aclk) begin
        int due;
        ncyc++;
        rd_busy = busy_force || (busy_rand && ($urandom_range(0, 3) == 0));
        rready  = (rready_mode == 1) ? 1'b1 : (rready_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (due_q.size() > 0 && due_q[0] <= ncyc) begin
            rd_valid = 1'b1;
            rd_data  = ret_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            rd_valid = 1'b0;
            rd_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
        rd_ack = 1'b0;
        if (aresetn) begin
            check("rd_en_eq", 128'(rd_en), 128'(rd_addr_en));
            if (pend) begin
                check("hold_en", 128'(rd_addr_en), 128'(1));
                check("hold_addr", 128'(rd_addr), 128'(pend_addr));
            end
            if (rd_addr_en) begin
                if (ack_wait >= ack_lat) begin
                    rd_ack = 1'b1;
                    check("rd_addr", 128'(rd_addr), 128'(exp_addr(ack_cnt)));
                    check("no_over_issue", 128'(ack_cnt <= int'(b_len)), 128'(1));
                    check("credit", 128'((ack_cnt + 1 - beat_cnt) <= FD), 128'(1));
                    due = ncyc + int'($urandom_range(ret_lat_min, ret_lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    ret_q.push_back(beat_data(ack_cnt, rd_addr));
                    due_q.push_back(due);
                    ack_cnt++;
                    ack_wait = 0;
                    ack_lat = int'($urandom_range(ack_lat_min, ack_lat_max));
                    pend = 1'b0;
                end else begin
                    ack_wait++;
                    pend = 1'b1;
                    pend_addr = rd_addr;
                end
            end else begin
                pend = 1'b0;
            end
            if (hold_chk) begin
                check("r_hold_vld", 128'(rvalid), 128'(1));
                check("r_hold_id", 128'(rid), 128'(hold_id));
                check("r_hold_data", rdata, hold_data);
                check("r_hold_last", 128'(rlast), 128'(hold_last));
            end
            hold_chk = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    check("r_data", rdata, beat_data(beat_cnt, exp_addr(beat_cnt)));
                    check("r_last", 128'(rlast), 128'(beat_cnt == int'(b_len)));
                    check("r_id", 128'(rid), 128'(b_id));
                    check("r_resp_user", 128'({rresp, ruser}), 128'(0));
                    if (beat_cnt == int'(b_len)) burst_done = 1'b1;
                    beat_cnt++;
                    total_beats++;
                end else begin
                    hold_chk  = 1'b1;
                    hold_id   = rid;
                    hold_data = rdata;
                    hold_last = rlast;
                end
            end
        end else begin
            pend = 1'b0;
            hold_chk = 1'b0;
            ack_wait = 0;
        end
    end

    task automatic wait_burst(input int limit);
        int n = 0;
        do begin
            @(negedge aclk); #3;
            n++;
        end while (!burst_done && n < limit);
        check("burst_done", 128'(burst_done), 128'(1));
        @(negedge aclk); #3;
        check("arready_after", 128'(arready), 128'(1));
    endtask

    task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input bit wait_done);
        int n = 0;
        @(negedge aclk);
        b_id = id; b_addr = addr; b_len = len; b_fixed = (burst == 2'b00); b_salt = $urandom;
        ack_cnt = 0; beat_cnt = 0; burst_done = 1'b0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        while (!arready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("ar_accept", 128'(arready), 128'(1));
        @(posedge aclk); #1;
        arvalid = 1'b0; arid = IW'($urandom); araddr = $urandom; arlen = 8'($urandom);
        @(negedge aclk); #2;
        check("arready_low", 128'(arready), 128'(0));
        if (!busy_rand && !busy_force) check("first_issue", 128'(rd_addr_en), 128'(1));
        if (wait_done) wait_burst(2000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] stall0;
        stall0 = '0;
        repeat (3) @(negedge aclk);
        #2;
        check("rst_arready", 128'(arready), 128'(0));
        check("rst_rvalid", 128'(rvalid), 128'(0));
        check("rst_rlast", 128'(rlast), 128'(0));
        check("rst_en", 128'({rd_addr_en, rd_en}), 128'(0));
        check("rst_rd_addr", 128'(rd_addr), 128'(0));
        check("rst_rid", 128'(rid), 128'(0));
        check("rst_rdata", rdata, 128'(0));
        aresetn = 1'b1;
        #1;
        check("arready_pre", 128'(arready), 128'(0));
        @(negedge aclk); #2;
        check("arready_post_rst", 128'(arready), 128'(1));

        // Single beat, then short INCR and FIXED bursts
        do_burst(8'h5A, 32'h0000_0100, 8'd0, 2'b01, 1'b1);
        check("single_acks", 128'(ack_cnt), 128'(1));
        do_burst(8'h11, 32'h0000_0000, 8'd7, 2'b01, 1'b1);
        check("incr_acks", 128'(ack_cnt), 128'(8));
        do_burst(8'h22, 32'h0000_0040, 8'd3, 2'b00, 1'b1);
        check("fixed_beats", 128'(beat_cnt), 128'(4));
        do_burst(8'h33, 32'hFFFF_FFE0, 8'd3, 2'b01, 1'b1);
        check("wrap_beats", 128'(beat_cnt), 128'(4));

        // Backpressure fills all credits
        rready_mode = 0;
        do_burst(8'h44, 32'h0000_1000, 8'd31, 2'b01, 1'b0);
        repeat (60) @(negedge aclk);
        #3;
        check("bp_acks", 128'(ack_cnt), 128'(FD));
        check("bp_en_low", 128'(rd_addr_en), 128'(0));
        rready_mode = 1;
        wait_burst(400);
        check("bp_beats", 128'(beat_cnt), 128'(32));

        // rd_busy held for 20 cycles mid-burst with slow acks
        ack_lat_min = 5; ack_lat_max = 5; ack_lat = 5;
        do_burst(8'h55, 32'h0000_2000, 8'd7, 2'b10, 1'b0);
        n = 0;
        while (ack_cnt < 2 && n < 200) begin
            @(negedge aclk); #3;
            n++;
        end
`ifdef RD_ENGINE_PERF_CNT_EN
        stall0 = rd_stall_cnt;
`endif
        busy_force = 1'b1;
        repeat (20) @(negedge aclk);
        #3;
        busy_force = 1'b0;
        wait_burst(400);
        check("busy_acks", 128'(ack_cnt), 128'(8));
`ifdef RD_ENGINE_PERF_CNT_EN
        check("stall_ge20", 128'((rd_stall_cnt - stall0) >= 32'd20), 128'(1));
`endif
        ack_lat_min = 0; ack_lat_max = 0; ack_lat = 0;

        // Randomized bursts
        rready_mode = 2; busy_rand = 1'b1; ack_lat_max = 2; ret_lat_min = 1; ret_lat_max = 6;
        for (int i = 0; i < 12; i++) begin
            do_burst(8'($urandom), $urandom, 8'($urandom_range(0, 23)), 2'($urandom_range(0, 3)), 1'b1);
        end
`ifdef RD_ENGINE_PERF_CNT_EN
        check("perf_beats", 128'(rd_beat_cnt), 128'(total_beats));
`endif
        rready_mode = 1; busy_rand = 1'b0; ack_lat_max = 0; ack_lat = 0; ret_lat_min = 3; ret_lat_max = 3;

        // Reset in the middle of an 8-beat burst
        do_burst(8'h66, 32'h0000_3000, 8'd7, 2'b01, 1'b0);
        n = 0;
        while (beat_cnt < 3 && n < 200) begin
            @(negedge aclk); #3;
            n++;
        end
        @(posedge aclk); #2;
        aresetn = 1'b0;
        total_beats = 0;
        #1;
        check("mid_arready", 128'(arready), 128'(0));
        check("mid_rvalid", 128'({rvalid, rlast}), 128'(0));
        check("mid_en", 128'({rd_addr_en, rd_en}), 128'(0));
        check("mid_rd_addr", 128'(rd_addr), 128'(0));
        check("mid_rid_rdata", 128'(rid) | rdata, 128'(0));
`ifdef RD_ENGINE_PERF_CNT_EN
        check("mid_perf", 128'({rd_beat_cnt, rd_stall_cnt}), 128'(0));
`endif
        @(negedge aclk); #2;
        aresetn = 1'b1;
        repeat (8) begin
            @(negedge aclk); #3;
            check("stale_ignored", 128'(rvalid), 128'(0));
        end
        do_burst(8'h77, 32'h0000_4000, 8'd5, 2'b01, 1'b1);
        check("fresh_beats", 128'(beat_cnt), 128'(6));
`ifdef RD_ENGINE_PERF_CNT_EN
        check("fresh_perf", 128'(rd_beat_cnt), 128'(6));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_axi_rd_engine.md
Name: ddr_axi_rd_engine

Overview:
- AXI4 read-path engine between the AXI slave AR/R channels and the simple_ddr native read port.
- Accepts one AR burst at a time and splits it into single-beat native reads.
- Buffers returned rd_data in an internal FIFO.
- Drives the R channel with backpressure. Outstanding requests are credit-limited so the non-stallable rd_valid return can never overflow the FIFO.

Parameters:
DATA_WIDTH, 128, data bus width; one native read equals one AXI beat
ADDR_WIDTH, 32, address width
ID_WIDTH, 8, AXI ID width
RUSER_WIDTH, 1, ruser width
FIFO_DEPTH, 16, read-return FIFO entries (power of 2, at least 2)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arid  in  ID_WIDTH  burst ID
araddr  in  ADDR_WIDTH  start byte address
arlen  in  8  beats minus 1
arburst  in  2  00 FIXED, 01 INCR, 10/11 treated as INCR
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  latched arid
rdata  out  DATA_WIDTH  FIFO head data
rresp  out  2  constant 2'b00
rlast  out  1  last beat of burst
ruser  out  RUSER_WIDTH  constant 0
rvalid  out  1  R valid
rready  in  1  R ready
rd_busy  in  1  controller cannot accept a request
rd_addr  out  ADDR_WIDTH  native read address
rd_addr_en  out  1  request strobe
rd_en  out  1  identical to rd_addr_en
rd_ack  in  1  controller accepted the held request
rd_data  in  DATA_WIDTH  returned data
rd_valid  in  1  returned data valid, in order, no backpressure

Behaviour:
- Reset values:
  - arready=0, rvalid=0, rlast=0, rd_addr_en=0, rd_en=0.
  - rd_addr=0, rid=0, rdata=0.
  - FIFO empty, all counters 0, state IDLE.
- FSM IDLE:
  - arready=1 one cycle after reset release.
  - On arvalid&arready: latch arid, araddr, arlen, arburst. Clear issue_cnt, ret_cnt and rbeat_cnt. Go to ISSUE. arready=0 from the next cycle.
- FSM ISSUE:
  - When no request is held, credit>0 and rd_busy=0: assert rd_addr_en=rd_en=1 with rd_addr=cur_addr.
  - Hold the request until rd_ack is sampled high.
  - On rd_ack: issue_cnt+1, outstanding+1. cur_addr += DATA_WIDTH/8 for INCR; unchanged for FIXED. The address wraps modulo 2^ADDR_WIDTH.
  - When issue_cnt reaches arlen+1 after an ack, go to DRAIN.
  - A new request may be strobed in the cycle after rd_ack.
- FSM DRAIN:
  - Stay until the R handshake with rlast=1, then go to IDLE. arready=1 in the next cycle.
- Latency: first rd_addr_en is asserted the cycle after the AR handshake.
- Credit:
  - credit = FIFO_DEPTH - (outstanding + fifo_count).
  - outstanding +1 on rd_ack and -1 on rd_valid; simultaneous events net to 0.
  - Issue is blocked at credit=0, so a FIFO push always has space.
- FIFO:
  - rd_valid pushes rd_data. The push is registered, so rvalid appears the cycle after rd_valid into an empty FIFO.
  - The FIFO is show-ahead: rvalid = !empty and rdata = head.
  - Pop on rvalid&rready. Push and pop in the same cycle keep the count.
- R channel:
  - rbeat_cnt increments on each R handshake.
  - rlast = rvalid & (rbeat_cnt == latched arlen).
  - rid and rdata are held stable while rvalid & !rready.
- rd_valid arriving while outstanding=0 is ignored, e.g. stale data after a reset.
- Reset mid-burst: all state is cleared immediately and asynchronously. Returned data from the aborted burst is dropped by the rule above.
- rresp is always OKAY. arsize and arlock are not inputs; full-width beats apply.

Optional Feature:
- Macro RD_ENGINE_PERF_CNT_EN.
- When defined, add output ports:
  - rd_beat_cnt[31:0]: +1 per R handshake.
  - rd_stall_cnt[31:0]: +1 per cycle with a request pending and blocked by rd_busy=1 or credit=0.
- Both counters reset to 0, saturate at 0xFFFFFFFF, and are never cleared except by aresetn.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single beat: araddr=0x100, arlen=0, INCR; controller acks immediately and returns data 0xA5 after 3 cycles -> one rd_addr_en at 0x100, then rvalid with rdata=0xA5, rlast=1, rid=arid, rresp=0; arready high again the cycle after the R handshake.
- INCR burst: araddr=0x0, arlen=7, rready=1 -> rd_addr sequence 0x00,0x10,…,0x70; 8 beats in order; rlast only on beat 8.
- Backpressure: arlen=31, rready=0 for 60 cycles -> exactly 16 requests acked, then rd_addr_en stays low; after rready=1, all 32 beats delivered in order with no loss or duplicates.
- rd_busy high for 20 cycles mid-burst and rd_ack delayed 5 cycles -> request held stable with unchanged rd_addr; no duplicate issue; with RD_ENGINE_PERF_CNT_EN, rd_stall_cnt increases by at least 20.
- FIXED burst: araddr=0x40, arburst=00, arlen=3 -> four requests all at 0x40, 4 beats returned, rlast on beat 4.
- Reset mid-burst: aresetn low at beat 3 of 8 -> outputs at reset values immediately; late rd_valid ignored; a fresh burst after reset completes correctly.
